ptw_req_arbiter: RTL and testbench

- Shares the single page-table-walker (PTW) port between N TLB requesters, e.g. ITLB and DTLB.
- Round-robin arbitration with one walk outstanding at a time.
- Returns the walk result (ppn, u, ae_ptw, ae_final, pf, gf, sx, px) to the requester that issued the walk.
- Sits between the TLBs and the PTW. Its response-field outputs feed the TLB-side optimization barrier on the refill path.

---
 rtl/ptw_req_arbiter.sv | 151 +++++++++++++++
 tb/tb_ptw_req_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ptw_req_arbiter.sv
// Shares one page-table-walker port between N_REQ TLBs, round-robin, one walk in flight.
// Latency: grant -> ptw_req_valid next cycle; ptw_resp_valid -> resp_valid next cycle.
// Backpressure: ptw_req_valid/ptw_req_vpn held until ptw_req_ready; no new grant until the walk retires.
module ptw_req_arbiter #(
    parameter int N_REQ = 2,
    parameter int VPN_W = 27,
    parameter int PPN_W = 20
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*VPN_W-1:0] req_vpn,
    input  logic                   flush,
    output logic                   ptw_req_valid,
    input  logic                   ptw_req_ready,
    output logic [VPN_W-1:0]       ptw_req_vpn,
    input  logic                   ptw_resp_valid,
    input  logic [PPN_W-1:0]       ptw_resp_ppn,
    input  logic [6:0]             ptw_resp_flags,
    output logic [N_REQ-1:0]       resp_valid,
    output logic [PPN_W-1:0]       resp_ppn,
    output logic [6:0]             resp_flags,
    output logic                   spurious_resp
);

    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]    owner_q, owner_d;
    logic [VPN_W-1:0]   vpn_q, vpn_d;
    logic               kill_q, kill_d;
    logic [PPN_W-1:0]   resp_ppn_q, resp_ppn_d;
    logic [6:0]         resp_flags_q, resp_flags_d;
    logic               spurious_q, spurious_d;

    logic               grant_vld;
    logic [ID_W-1:0]    grant_idx;
    logic [ID_W:0]      scan_idx;
    logic [ID_W-1:0]    rr_next;

    // Scan from the highest offset down so the requester closest to rr_ptr wins.
    // The extra bit on scan_idx lets non-power-of-2 N_REQ wrap by compare.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            scan_idx = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (scan_idx >= (ID_W+1)'(N_REQ)) begin
                scan_idx = scan_idx - (ID_W+1)'(N_REQ);
            end
            if (req_valid[scan_idx[ID_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = scan_idx[ID_W-1:0];
            end
        end
    end

    assign rr_next = (owner_q == ID_W'(N_REQ - 1)) ? '0 : owner_q + ID_W'(1);

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        owner_d      = owner_q;
        vpn_d        = vpn_q;
        kill_d       = kill_q;
        resp_ppn_d   = resp_ppn_q;
        resp_flags_d = resp_flags_q;
        spurious_d   = spurious_q | (ptw_resp_valid && (state_q != WAIT));
        req_ready     = '0;
        ptw_req_valid = 1'b0;
        resp_valid    = '0;

        case (state_q)
            IDLE: begin
                // req_ready is combinational, so mask it while reset is asserted.
                if (grant_vld && !flush && !reset) begin
                    req_ready[grant_idx] = 1'b1;
                    owner_d = grant_idx;
                    vpn_d   = req_vpn[grant_idx*VPN_W +: VPN_W];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                ptw_req_valid = 1'b1;
                if (ptw_req_ready) begin
                    kill_d  = flush;
                    state_d = WAIT;
                end else if (flush) begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (flush) begin
                    kill_d = 1'b1;
                end
                if (ptw_resp_valid) begin
                    resp_ppn_d   = ptw_resp_ppn;
                    resp_flags_d = ptw_resp_flags;
                    state_d      = RESP;
                end
            end
            RESP: begin
                if (!kill_q) begin
                    resp_valid[owner_q] = 1'b1;
                end
                kill_d   = 1'b0;
                rr_ptr_d = rr_next;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            owner_q      <= '0;
            vpn_q        <= '0;
            kill_q       <= 1'b0;
            resp_ppn_q   <= '0;
            resp_flags_q <= '0;
            spurious_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            owner_q      <= owner_d;
            vpn_q        <= vpn_d;
            kill_q       <= kill_d;
            resp_ppn_q   <= resp_ppn_d;
            resp_flags_q <= resp_flags_d;
            spurious_q   <= spurious_d;
        end
    end

    assign ptw_req_vpn   = vpn_q;
    assign resp_ppn      = resp_ppn_q;
    assign resp_flags    = resp_flags_q;
    assign spurious_resp = spurious_q;

endmodule

// File: tb/tb_ptw_req_arbiter.sv
// Bench for ptw_req_arbiter: transaction-level model compared every cycle plus directed literal checks.
module tb_ptw_req_arbiter;

    localparam int N  = 2;
    localparam int VW = 27;
    localparam int PW = 20;

    logic              clock = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*VW-1:0]   req_vpn;
    logic              flush;
    logic              ptw_req_valid;
    logic              ptw_req_ready;
    logic [VW-1:0]     ptw_req_vpn;
    logic              ptw_resp_valid;
    logic [PW-1:0]     ptw_resp_ppn;
    logic [6:0]        ptw_resp_flags;
    logic [N-1:0]      resp_valid;
    logic [PW-1:0]     resp_ppn;
    logic [6:0]        resp_flags;
    logic              spurious_resp;

    always #5 clock = ~clock;

    ptw_req_arbiter #(.N_REQ(N), .VPN_W(VW), .PPN_W(PW)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_vpn(req_vpn),
        .flush(flush),
        .ptw_req_valid(ptw_req_valid), .ptw_req_ready(ptw_req_ready), .ptw_req_vpn(ptw_req_vpn),
        .ptw_resp_valid(ptw_resp_valid), .ptw_resp_ppn(ptw_resp_ppn), .ptw_resp_flags(ptw_resp_flags),
        .resp_valid(resp_valid), .resp_ppn(resp_ppn), .resp_flags(resp_flags),
        .spurious_resp(spurious_resp)
    );

    int checks   = 0;
    int failures = 0;

    // Model of one walk's lifecycle: granted (busy), accepted by PTW (sent), result being returned (deliver).
    bit            m_busy, m_sent, m_deliver, m_kill, m_spur;
    int            m_owner, m_rr;
    logic [VW-1:0] m_vpn;
    logic [PW-1:0] m_ppn;
    logic [6:0]    m_flags;

    int grant_log[$];
    int strobe_cnt[N];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick();
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_rr + k) % N;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_clear();
        m_busy = 0; m_sent = 0; m_deliver = 0; m_kill = 0; m_spur = 0;
        m_owner = 0; m_rr = 0; m_vpn = '0; m_ppn = '0; m_flags = '0;
    endtask

    task automatic idle_inputs();
        req_valid = '0; flush = 0; ptw_req_ready = 0;
        ptw_resp_valid = 0; ptw_resp_ppn = '0; ptw_resp_flags = '0;
    endtask

    // Compare on the falling edge, then advance the model with the inputs the DUT will see on the rising edge.
    task automatic step();
        logic [N-1:0] er, erv;
        int g;
        bit epv;
        @(negedge clock);
        g  = pick();
        er = '0;
        if (!m_busy && !m_deliver && !flush && g >= 0) er[g] = 1'b1;
        epv = m_busy && !m_sent;
        erv = '0;
        if (m_deliver && !m_kill) erv[m_owner] = 1'b1;

        chk("req_ready", 64'(req_ready), 64'(er));
        chk("req_ready_onehot", 64'($countones(req_ready) <= 1), 64'(1));
        chk("ptw_req_valid", 64'(ptw_req_valid), 64'(epv));
        if (epv) chk("ptw_req_vpn", 64'(ptw_req_vpn), 64'(m_vpn));
        chk("resp_valid", 64'(resp_valid), 64'(erv));
        chk("resp_ppn", 64'(resp_ppn), 64'(m_ppn));
        chk("resp_flags", 64'(resp_flags), 64'(m_flags));
        chk("spurious_resp", 64'(spurious_resp), 64'(m_spur));

        for (int i = 0; i < N; i++) begin
            if (req_ready[i]) grant_log.push_back(i);
            if (resp_valid[i]) strobe_cnt[i]++;
        end

        if (ptw_resp_valid && !(m_busy && m_sent)) m_spur = 1;
        if (m_deliver) begin
            m_deliver = 0;
            m_kill    = 0;
            m_rr      = (m_owner + 1) % N;
        end else if (!m_busy) begin
            if (er != '0) begin
                m_busy  = 1;
                m_sent  = 0;
                m_owner = g;
                m_vpn   = req_vpn[g*VW +: VW];
            end
        end else if (!m_sent) begin
            if (ptw_req_ready) begin
                m_sent = 1;
                m_kill = flush;
            end else if (flush) begin
                m_busy = 0;
            end
        end else begin
            if (flush) m_kill = 1;
            if (ptw_resp_valid) begin
                m_ppn     = ptw_resp_ppn;
                m_flags   = ptw_resp_flags;
                m_busy    = 0;
                m_sent    = 0;
                m_deliver = 1;
            end
        end
        @(posedge clock);
        #1;
    endtask

    // Asserts reset mid-cycle, checks the asynchronous clear, then leaves the bench just after a rising edge.
    task automatic do_reset();
        reset = 1'b1;
        #2;
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        chk("rst_ptw_req_valid", 64'(ptw_req_valid), 64'(0));
        chk("rst_ptw_req_vpn", 64'(ptw_req_vpn), 64'(0));
        chk("rst_resp_valid", 64'(resp_valid), 64'(0));
        chk("rst_resp_ppn", 64'(resp_ppn), 64'(0));
        chk("rst_resp_flags", 64'(resp_flags), 64'(0));
        chk("rst_spurious", 64'(spurious_resp), 64'(0));
        idle_inputs();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_clear();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [VW-1:0] v;
        int delivered;
        idle_inputs();
        req_vpn = '0;
        reset   = 1'b0;
        model_clear();
        #3;
        do_reset();

        // Single request, response on the second WAIT cycle.
        req_vpn[0 +: VW] = 27'h1234567;
        req_valid = 2'b01;
        ptw_req_ready = 1;
        step();
        req_valid = 2'b00;
        #1;
        chk("t1_ptw_req_valid", 64'(ptw_req_valid), 64'(1));
        chk("t1_ptw_req_vpn", 64'(ptw_req_vpn), 64'h1234567);
        step();
        ptw_req_ready = 0;
        step();
        ptw_resp_valid = 1; ptw_resp_ppn = 20'hABCDE; ptw_resp_flags = 7'b1000001;
        step();
        idle_inputs();
        #1;
        chk("t1_resp_valid", 64'(resp_valid), 64'(2'b01));
        chk("t1_resp_ppn", 64'(resp_ppn), 64'hABCDE);
        chk("t1_resp_flags", 64'(resp_flags), 64'h41);
        step();
        chk("t1_resp_valid_drop", 64'(resp_valid), 64'(0));
        chk("t1_resp_ppn_hold", 64'(resp_ppn), 64'hABCDE);

        // Contention fairness: four back-to-back walks with both requesters asking.
        do_reset();
        grant_log.delete();
        strobe_cnt[0] = 0; strobe_cnt[1] = 0;
        req_vpn = {27'h0BBBBBB, 27'h0AAAAAA};
        delivered = 0;
        for (int c = 0; c < 40 && delivered < 4; c++) begin
            req_valid = 2'b11;
            ptw_req_ready = 1;
            ptw_resp_valid = m_busy && m_sent;
            ptw_resp_ppn = PW'($urandom);
            ptw_resp_flags = 7'($urandom);
            if (m_deliver) delivered++;
            step();
        end
        idle_inputs();
        step();
        chk("t2_grant_count", 64'(grant_log.size() >= 4), 64'(1));
        if (grant_log.size() >= 4) begin
            chk("t2_grant0", 64'(grant_log[0]), 64'(0));
            chk("t2_grant1", 64'(grant_log[1]), 64'(1));
            chk("t2_grant2", 64'(grant_log[2]), 64'(0));
            chk("t2_grant3", 64'(grant_log[3]), 64'(1));
        end
        chk("t2_strobes0", 64'(strobe_cnt[0]), 64'(2));
        chk("t2_strobes1", 64'(strobe_cnt[1]), 64'(2));

        // PTW backpressure for 5 cycles in ISSUE.
        do_reset();
        v = VW'($urandom);
        req_vpn[0 +: VW] = v;
        req_valid = 2'b01;
        step();
        req_valid = 2'b11;
        ptw_req_ready = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("t3_hold_valid", 64'(ptw_req_valid), 64'(1));
            chk("t3_hold_vpn", 64'(ptw_req_vpn), 64'(v));
            chk("t3_no_grant", 64'(req_ready), 64'(0));
            step();
        end
        ptw_req_ready = 1;
        step();
        ptw_req_ready = 0;
        req_valid = 2'b00;
        ptw_resp_valid = 1; ptw_resp_ppn = PW'($urandom); ptw_resp_flags = 7'($urandom);
        step();
        idle_inputs();
        step();

        // Flush one cycle into WAIT, response three cycles later is swallowed.
        do_reset();
        req_vpn = {27'h7654321, 27'h0111111};
        req_valid = 2'b01;
        step();
        req_valid = 2'b00;
        ptw_req_ready = 1;
        step();
        ptw_req_ready = 0;
        step();
        flush = 1;
        step();
        flush = 0;
        step();
        step();
        ptw_resp_valid = 1; ptw_resp_ppn = 20'h12345; ptw_resp_flags = 7'b0001000;
        step();
        idle_inputs();
        #1;
        chk("t4_killed_resp", 64'(resp_valid), 64'(0));
        step();
        req_valid = 2'b10;
        #1;
        chk("t4_regrant", 64'(req_ready), 64'(2'b10));
        step();
        req_valid = 2'b00;
        ptw_req_ready = 1;
        step();
        ptw_req_ready = 0;
        ptw_resp_valid = 1; ptw_resp_ppn = 20'h0FACE; ptw_resp_flags = 7'b0000010;
        step();
        idle_inputs();
        #1;
        chk("t4_next_resp", 64'(resp_valid), 64'(2'b10));
        chk("t4_next_ppn", 64'(resp_ppn), 64'h0FACE);
        step();

        // Flush in ISSUE without ptw_req_ready: walk dropped, same requester regranted.
        do_reset();
        req_valid = 2'b11;
        step();
        ptw_req_ready = 0;
        flush = 1;
        step();
        flush = 0;
        #1;
        chk("t5_ptw_req_drop", 64'(ptw_req_valid), 64'(0));
        chk("t5_same_grant", 64'(req_ready), 64'(2'b01));
        step();
        req_valid = 2'b00;
        step();

        // Reset in WAIT, then a stray response while idle.
        req_valid = 2'b11;
        ptw_req_ready = 1;
        step();
        req_valid = 2'b11;
        #1;
        do_reset();
        ptw_resp_valid = 1; ptw_resp_ppn = 20'h55555; ptw_resp_flags = 7'h7F;
        step();
        idle_inputs();
        #1;
        chk("t6_spurious", 64'(spurious_resp), 64'(1));
        chk("t6_no_resp", 64'(resp_valid), 64'(0));
        step();

        // Randomized traffic.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            req_valid = N'($urandom_range(0, 3));
            req_vpn = {VW'($urandom), VW'($urandom)};
            flush = ($urandom_range(0, 15) == 0);
            ptw_req_ready = $urandom_range(0, 1) == 1;
            if (m_busy && m_sent) ptw_resp_valid = ($urandom_range(0, 9) < 4);
            else ptw_resp_valid = ($urandom_range(0, 63) == 0);
            ptw_resp_ppn = PW'($urandom);
            ptw_resp_flags = 7'($urandom);
            step();
        end
        idle_inputs();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
